fpu_issue_arbiter: RTL and testbench

- Shares the single 6-cycle, non-stallable FPU pipeline between two requesters.
- Round-robin arbitration on a valid/ready request interface; at most one issue per cycle.
- Tracks every in-flight op (requester id + tag) in a LATENCY-deep shift register, so each result returns to its owner with its tag.
- Supports an in-flight cap and a drain/idle handshake for quiescing before mode changes.

---
 rtl/fpu_issue_arbiter_if.sv | 72 +++++++
 rtl/fpu_issue_arbiter.sv | 121 ++++++++++++
 tb/tb_fpu_issue_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_issue_arbiter_if.sv
// ----------------------------------------------------------------------------
// fpu_issue_arbiter_if
//   Bundles the requester handshakes, the FPU-side operand/result lines, the
//   response channel and the drain/idle quiesce handshake of fpu_issue_arbiter.
//
//   Signal groups:
//     req0_* / req1_*  valid/ready request channels (op1, op2, operation, tag)
//     fpu_*            operands/operation to the FPU, result back from it
//     rsp_*            tagged response to the owning requester (no backpressure)
//     drain/idle       quiesce request and "nothing in flight" status
//     inflight         current number of ops inside the FPU pipeline
//
//   Modports:
//     slave   - the arbiter itself
//     master  - the environment (requesters + FPU + control)
// ----------------------------------------------------------------------------
interface fpu_issue_arbiter_if #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 3
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_op1;
    logic [31:0]      req0_op2;
    logic [1:0]       req0_operation;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_op1;
    logic [31:0]      req1_op2;
    logic [1:0]       req1_operation;
    logic [TAG_W-1:0] req1_tag;

    logic [31:0]      fpu_operand1;
    logic [31:0]      fpu_operand2;
    logic [1:0]       fpu_operation;
    logic [31:0]      fpu_result;

    logic             rsp_valid;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_result;

    logic             drain;
    logic             idle;
    logic [CNT_W-1:0] inflight;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_operation, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op1, req1_op2, req1_operation, req1_tag,
        output req1_ready,
        output fpu_operand1, fpu_operand2, fpu_operation,
        input  fpu_result,
        output rsp_valid, rsp_id, rsp_tag, rsp_result,
        input  drain,
        output idle, inflight
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_operation, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op1, req1_op2, req1_operation, req1_tag,
        input  req1_ready,
        input  fpu_operand1, fpu_operand2, fpu_operation,
        output fpu_result,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result,
        output drain,
        input  idle, inflight
    );
endinterface

// File: rtl/fpu_issue_arbiter.sv
// ----------------------------------------------------------------------------
// fpu_issue_arbiter
//   Shares one fixed-latency, non-stallable FPU pipeline between two
//   requesters. Round-robin arbitration issues at most one op per cycle; a
//   LATENCY-deep tracking shift register remembers {valid, id, tag} of each
//   op so the FPU result can be routed back to its owner in cycle N+LATENCY.
//   An in-flight cap limits outstanding ops and drain/idle lets software
//   quiesce the unit.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - fpu_issue_arbiter_if.slave (request, FPU, response, drain/idle)
// ----------------------------------------------------------------------------
module fpu_issue_arbiter #(
    parameter int LATENCY      = 6,
    parameter int TAG_W        = 4,
    parameter int MAX_INFLIGHT = 6,
    parameter int CNT_W        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    fpu_issue_arbiter_if.slave    bus
);

    // Round-robin pointer: requester favoured when both are valid.
    logic             rr_q, rr_d;
    // Tracking pipeline: slot LATENCY-1 lines up with fpu_result.
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] id_q;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    logic [CNT_W-1:0]   inflight_q, inflight_d;

    logic             retire;
    logic             en;
    logic             grant0, grant1;
    logic             issue;
    logic [TAG_W-1:0] issue_tag;

    assign retire = vld_q[LATENCY-1];

    // A retiring slot frees a place in the same cycle, so a full pipeline
    // still accepts one new op alongside a retire. Reset gates grants so
    // ready and fpu_* are forced low while rst is held.
    assign en = !rst && !bus.drain &&
                ((inflight_q < CNT_W'(MAX_INFLIGHT)) || retire);

    // NOTE: every signal written here gets a default first; a missing branch
    // would otherwise infer a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (en) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = !rr_q;
                grant1 = rr_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign issue          = grant0 | grant1;
    assign issue_tag      = grant1 ? bus.req1_tag : bus.req0_tag;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Bubbles send zeros into the FPU; they are tracked as invalid slots.
    always_comb begin
        bus.fpu_operand1  = '0;
        bus.fpu_operand2  = '0;
        bus.fpu_operation = '0;
        if (grant0) begin
            bus.fpu_operand1  = bus.req0_op1;
            bus.fpu_operand2  = bus.req0_op2;
            bus.fpu_operation = bus.req0_operation;
        end else if (grant1) begin
            bus.fpu_operand1  = bus.req1_op1;
            bus.fpu_operand2  = bus.req1_op2;
            bus.fpu_operation = bus.req1_operation;
        end
    end

    // After serving X, point at the other requester; hold on no grant.
    assign rr_d       = issue ? !grant1 : rr_q;
    assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(retire);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= 1'b0;
            vld_q      <= '0;
            inflight_q <= '0;
        end else begin
            rr_q       <= rr_d;
            vld_q      <= {vld_q[LATENCY-2:0], issue};
            inflight_q <= inflight_d;
        end
    end

    // NOTE: only the valid bits are reset; id/tag payload is meaningless while
    // its valid bit is low, so it needs no reset network.
    always_ff @(posedge clk) begin
        id_q     <= {id_q[LATENCY-2:0], grant1};
        tag_q[0] <= issue_tag;
        for (int k = 1; k < LATENCY; k++) begin
            tag_q[k] <= tag_q[k-1];
        end
    end

    assign bus.rsp_valid  = retire;
    assign bus.rsp_id     = id_q[LATENCY-1];
    assign bus.rsp_tag    = tag_q[LATENCY-1];
    assign bus.rsp_result = bus.fpu_result;

    assign bus.idle     = (inflight_q == '0);
    assign bus.inflight = inflight_q;

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fpu_issue_arbiter
//   Two arbiter instances (MAX_INFLIGHT 6 and 3) see identical stimulus. Each
//   drives its own behavioural 6-cycle FPU. A scoreboard indexed by due cycle
//   predicts grants, FPU operands, responses, idle and inflight per instance.
// ----------------------------------------------------------------------------
module tb_fpu_issue_arbiter;

    localparam int LAT = 6;

    logic clk;
    logic rst;

    logic        v0, v1, drain;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  op0, op1;
    logic [3:0]  t0, t1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    fpu_issue_arbiter_if #(.TAG_W(4), .CNT_W(3)) if0 ();
    fpu_issue_arbiter_if #(.TAG_W(4), .CNT_W(3)) if1 ();

    fpu_issue_arbiter #(.LATENCY(LAT), .TAG_W(4), .MAX_INFLIGHT(6), .CNT_W(3)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    fpu_issue_arbiter #(.LATENCY(LAT), .TAG_W(4), .MAX_INFLIGHT(3), .CNT_W(3)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    assign if0.req0_valid = v0;  assign if1.req0_valid = v0;
    assign if0.req0_op1 = a0;    assign if1.req0_op1 = a0;
    assign if0.req0_op2 = b0;    assign if1.req0_op2 = b0;
    assign if0.req0_operation = op0; assign if1.req0_operation = op0;
    assign if0.req0_tag = t0;    assign if1.req0_tag = t0;
    assign if0.req1_valid = v1;  assign if1.req1_valid = v1;
    assign if0.req1_op1 = a1;    assign if1.req1_op1 = a1;
    assign if0.req1_op2 = b1;    assign if1.req1_op2 = b1;
    assign if0.req1_operation = op1; assign if1.req1_operation = op1;
    assign if0.req1_tag = t1;    assign if1.req1_tag = t1;
    assign if0.drain = drain;    assign if1.drain = drain;

    // Stand-in FPU arithmetic: any deterministic mix of the inputs shows
    // whether the right operands were routed and the result returned intact.
    function automatic logic [31:0] fpu_f(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] op);
        return (x * 32'd3 + y) ^ {op, 28'h0, ~op};
    endfunction

    // Behavioural fixed-latency FPU for each instance.
    logic [31:0] pipe0 [LAT];
    logic [31:0] pipe1 [LAT];
    always @(posedge clk) begin
        pipe0[0] <= fpu_f(if0.fpu_operand1, if0.fpu_operand2, if0.fpu_operation);
        pipe1[0] <= fpu_f(if1.fpu_operand1, if1.fpu_operand2, if1.fpu_operation);
        for (int k = 1; k < LAT; k++) begin
            pipe0[k] <= pipe0[k-1];
            pipe1[k] <= pipe1[k-1];
        end
    end
    assign if0.fpu_result = pipe0[LAT-1];
    assign if1.fpu_result = pipe1[LAT-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected response keyed by the cycle it is due (mod 16).
    bit        mv   [2][16];
    bit        mid  [2][16];
    bit [3:0]  mtag [2][16];
    bit [31:0] mres [2][16];
    bit        mrr  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step_dut(input int d);
        int        maxf;
        int        slot;
        int        pend;
        int        g;
        bit        retire;
        bit        en;
        logic      r0, r1, rv, rid, idl;
        logic [31:0] o1, o2, rres;
        logic [1:0]  fop;
        logic [3:0]  rtag;
        logic [2:0]  infl;
        logic [31:0] e1, e2;
        logic [1:0]  eop;
        string     p;

        maxf = (d == 0) ? 6 : 3;
        p    = (d == 0) ? "u0" : "u1";
        if (d == 0) begin
            r0 = if0.req0_ready; r1 = if0.req1_ready;
            o1 = if0.fpu_operand1; o2 = if0.fpu_operand2; fop = if0.fpu_operation;
            rv = if0.rsp_valid; rid = if0.rsp_id; rtag = if0.rsp_tag; rres = if0.rsp_result;
            idl = if0.idle; infl = if0.inflight;
        end else begin
            r0 = if1.req0_ready; r1 = if1.req1_ready;
            o1 = if1.fpu_operand1; o2 = if1.fpu_operand2; fop = if1.fpu_operation;
            rv = if1.rsp_valid; rid = if1.rsp_id; rtag = if1.rsp_tag; rres = if1.rsp_result;
            idl = if1.idle; infl = if1.inflight;
        end

        if (rst) begin
            for (int k = 0; k < 16; k++) mv[d][k] = 1'b0;
            mrr[d] = 1'b0;
        end

        slot   = cyc % 16;
        retire = mv[d][slot];
        pend   = 0;
        for (int k = 0; k < 16; k++) pend += int'(mv[d][k]);

        en = !rst && !drain && (pend < maxf || retire);
        g  = -1;
        if (en) begin
            if (v0 && v1) g = mrr[d] ? 1 : 0;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end

        e1 = '0; e2 = '0; eop = '0;
        if (g == 0) begin e1 = a0; e2 = b0; eop = op0; end
        if (g == 1) begin e1 = a1; e2 = b1; eop = op1; end

        check({p, "_ready0"}, 32'(r0), 32'(g == 0));
        check({p, "_ready1"}, 32'(r1), 32'(g == 1));
        check({p, "_fpu_op1"}, o1, e1);
        check({p, "_fpu_op2"}, o2, e2);
        check({p, "_fpu_operation"}, 32'(fop), 32'(eop));
        check({p, "_rsp_valid"}, 32'(rv), 32'(retire));
        if (retire) begin
            check({p, "_rsp_id"}, 32'(rid), 32'(mid[d][slot]));
            check({p, "_rsp_tag"}, 32'(rtag), 32'(mtag[d][slot]));
            check({p, "_rsp_result"}, rres, mres[d][slot]);
        end
        check({p, "_idle"}, 32'(idl), 32'(pend == 0));
        check({p, "_inflight"}, 32'(infl), 32'(pend));

        if (retire) mv[d][slot] = 1'b0;
        if (g >= 0) begin
            slot = (cyc + LAT) % 16;
            mv[d][slot]   = 1'b1;
            mid[d][slot]  = (g == 1);
            mtag[d][slot] = (g == 1) ? t1 : t0;
            mres[d][slot] = fpu_f(e1, e2, eop);
            mrr[d]        = (g == 0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        step_dut(0);
        step_dut(1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reqs();
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic rand_ops();
        a0 = $urandom; b0 = $urandom; op0 = 2'($urandom);
        a1 = $urandom; b1 = $urandom; op1 = 2'($urandom);
    endtask

    initial begin
        rst = 1'b1; drain = 1'b0;
        idle_reqs();
        rand_ops();
        t0 = '0; t1 = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single op from requester 0.
        v0 = 1'b1; a0 = 32'h3F80_0000; b0 = 32'h4000_0000; op0 = 2'b10; t0 = 4'd5;
        tick();
        idle_reqs();
        repeat (8) tick();

        // Both requesters valid for 8 cycles: alternating grants.
        for (int i = 0; i < 8; i++) begin
            v0 = 1'b1; v1 = 1'b1; t0 = 4'(i); t1 = 4'(i + 8);
            rand_ops();
            tick();
        end
        idle_reqs();
        repeat (10) tick();

        // Requester 0 always valid: exercises the in-flight cap of u1.
        for (int i = 0; i < 12; i++) begin
            v0 = 1'b1; t0 = 4'(i);
            rand_ops();
            tick();
        end
        idle_reqs();
        repeat (8) tick();

        // Four ops, then drain with both valid, then release drain.
        for (int i = 0; i < 4; i++) begin
            v0 = 1'b1; t0 = 4'(i);
            rand_ops();
            tick();
        end
        drain = 1'b1; v0 = 1'b1; v1 = 1'b1;
        repeat (8) tick();
        drain = 1'b0;
        repeat (2) tick();
        idle_reqs();
        repeat (8) tick();

        // Reset in the middle of three outstanding ops.
        for (int i = 0; i < 3; i++) begin
            v0 = 1'b1; t0 = 4'(i + 3);
            rand_ops();
            tick();
        end
        idle_reqs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        v0 = 1'b1; v1 = 1'b1; t0 = 4'd1; t1 = 4'd2;
        tick();
        idle_reqs();
        repeat (8) tick();

        // Bubble between two issues.
        v0 = 1'b1; t0 = 4'd7; rand_ops();
        tick();
        v0 = 1'b0;
        tick();
        v0 = 1'b1; t0 = 4'd8; rand_ops();
        tick();
        idle_reqs();
        repeat (8) tick();

        // Random traffic with occasional drain and reset.
        for (int i = 0; i < 3000; i++) begin
            v0    = ($urandom_range(0, 9) < 7);
            v1    = ($urandom_range(0, 9) < 6);
            drain = ($urandom_range(0, 19) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            t0    = 4'($urandom);
            t1    = 4'($urandom);
            rand_ops();
            tick();
        end
        rst = 1'b0; drain = 1'b0;
        idle_reqs();
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
